// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared codes for the multi-cycle RV32I control FSM
package multicycle_ctrl_pkg;
  localparam int ALUOPWIDTH = 3;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC} class_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [ALUOPWIDTH-1:0] ALU_NONE   = 3'd0;
  localparam logic [ALUOPWIDTH-1:0] ALU_R      = 3'd1;
  localparam logic [ALUOPWIDTH-1:0] ALU_I      = 3'd2;
  localparam logic [ALUOPWIDTH-1:0] ALU_BRANCH = 3'd3;
  localparam logic [ALUOPWIDTH-1:0] ALU_ADD    = 3'd4;
  localparam logic [ALUOPWIDTH-1:0] ALU_JUMP   = 3'd5;
  localparam logic [ALUOPWIDTH-1:0] ALU_LUI    = 3'd6;
  localparam logic SRC_REG = 1'b0;
  localparam logic SRC_IMM = 1'b1;
  // operand1 non-register source: zero for LUI, PC for AUIPC; ALUOp tells them apart
  localparam logic SRC1_REG = 1'b0;
  localparam logic SRC1_ZPC = 1'b1;
  localparam logic PCSRC_RS1 = 1'b0;
  localparam logic PCSRC_PPC = 1'b1;
  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_TGT  = 2'd1;
  localparam logic [1:0] PC_SEL_JALR = 2'd2;
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  typedef struct packed {
    logic [ALUOPWIDTH-1:0] alu_op;
    logic                  alu_src;
    logic                  alu_src1;
    logic                  pc_src;
  } ctl_t;
  function automatic ctl_t class_ctl(class_e c);
    ctl_t t;
    t = '{alu_op: ALU_NONE, alu_src: SRC_IMM, alu_src1: SRC1_REG, pc_src: PCSRC_RS1};
    case (c)
      C_R:      begin t.alu_op = ALU_R; t.alu_src = SRC_REG; end
      C_I:      t.alu_op = ALU_I;
      C_LOAD,
      C_STORE:  t.alu_op = ALU_ADD;
      C_BRANCH: begin t.alu_op = ALU_BRANCH; t.alu_src = SRC_REG; t.pc_src = PCSRC_PPC; end
      C_JAL:    begin t.alu_op = ALU_JUMP; t.pc_src = PCSRC_PPC; end
      C_JALR:   t.alu_op = ALU_JUMP;
      C_LUI:    begin t.alu_op = ALU_LUI; t.alu_src1 = SRC1_ZPC; end
      C_AUIPC:  begin t.alu_op = ALU_ADD; t.alu_src1 = SRC1_ZPC; end
      default:  t.alu_op = ALU_NONE;
    endcase
    return t;
  endfunction
  // funct7 only matters for R-type and the immediate shifts (funct3 001/101)
  function automatic logic keeps_funct7(class_e c, logic [2:0] f3);
    return c == C_R || (c == C_I && f3[1:0] == 2'b01);
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: ALU control, memory handshake and status bundle of the controller
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;
  logic [31:0]           instr;
  logic                  imem_req;
  logic                  imem_ready;
  logic                  dmem_req;
  logic                  dmem_we;
  logic                  dmem_ready;
  logic                  zero;
  logic [ALUOPWIDTH-1:0] ALUOp;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  ALUSrc;
  logic                  ALUSrc1;
  logic                  PCSrc;
  logic                  ir_write;
  logic                  pc_write;
  logic [1:0]            pc_sel;
  logic                  reg_write;
  logic [1:0]            wb_sel;
  logic                  retired;
  logic [31:0]           instret;
  logic                  illegal;
  logic                  timeout;
  modport master (
    input  instr, imem_ready, dmem_ready, zero,
    output imem_req, dmem_req, dmem_we, ALUOp, funct3, funct7, ALUSrc, ALUSrc1, PCSrc,
           ir_write, pc_write, pc_sel, reg_write, wb_sel, retired, instret, illegal, timeout
  );
  modport slave (
    output instr, imem_ready, dmem_ready, zero,
    input  imem_req, dmem_req, dmem_we, ALUOp, funct3, funct7, ALUSrc, ALUSrc1, PCSrc,
           ir_write, pc_write, pc_sel, reg_write, wb_sel, retired, instret, illegal, timeout
  );
endinterface

// File: rtl/multicycle_ctrl_instr_class_decode.sv
// multicycle_ctrl_instr_class_decode: RV32I opcode to instruction class, flags unsupported opcodes
module multicycle_ctrl_instr_class_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output class_e     cls,
  output logic       illegal
);
  // opcode lookup; anything unlisted is illegal
  always_comb begin
    cls = C_R;
    illegal = 1'b0;
    case (opcode)
      OP_R:      cls = C_R;
      OP_I:      cls = C_I;
      OP_LOAD:   cls = C_LOAD;
      OP_STORE:  cls = C_STORE;
      OP_BRANCH: cls = C_BRANCH;
      OP_JAL:    cls = C_JAL;
      OP_JALR:   cls = C_JALR;
      OP_LUI:    cls = C_LUI;
      OP_AUIPC:  cls = C_AUIPC;
      default:   illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer issuing ALU controls and memory handshakes
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);
  localparam logic [15:0] LIMIT = 16'(MEM_TIMEOUT - 1);
  state_e      state_q, state_d;
  class_e      cls_q, cls_d, dec_cls;
  logic        dec_illegal;
  logic [2:0]  f3_q, f3_d;
  logic [6:0]  f7_q, f7_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d, timeout_q, timeout_d;
  logic        ready;
  logic        unused_instr;
  ctl_t        ctl;

  multicycle_ctrl_instr_class_decode u_dec (
    .opcode (bus.instr[6:0]),
    .cls    (dec_cls),
    .illegal(dec_illegal)
  );

  assign ctl = class_ctl(cls_q);
  assign ready = state_q == S_MEM ? bus.dmem_ready : bus.imem_ready;
  assign instret_d = instret_q + {31'd0, bus.retired};
  assign unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};
  assign bus.instret = rst ? '0 : instret_q;
  assign bus.illegal = rst ? 1'b0 : illegal_q;
  assign bus.timeout = rst ? 1'b0 : timeout_q;

  // next state, wait counter and Moore controls; everything forced low while rst is high
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    f3_d = f3_q;
    f7_d = f7_q;
    wcnt_d = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel = PC_SEL_PC4;
    bus.reg_write = 1'b0;
    bus.wb_sel = WB_SEL_ALU;
    bus.retired = 1'b0;
    bus.ALUOp = ALU_NONE;
    bus.funct3 = '0;
    bus.funct7 = '0;
    bus.ALUSrc = SRC_REG;
    bus.ALUSrc1 = SRC1_REG;
    bus.PCSrc = PCSRC_RS1;
    if (!rst) begin
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
        bus.ALUOp = ctl.alu_op;
        bus.ALUSrc = ctl.alu_src;
        bus.ALUSrc1 = ctl.alu_src1;
        bus.PCSrc = ctl.pc_src;
        bus.funct3 = f3_q;
        bus.funct7 = f7_q;
      end
      if ((state_q == S_FETCH || state_q == S_MEM) && !ready) begin
        wcnt_d = wcnt_q + 16'd1;
        if (wcnt_q == LIMIT) begin
          state_d = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_write = ready;
          if (ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          cls_d = dec_cls;
          f3_d = bus.instr[14:12];
          f7_d = keeps_funct7(dec_cls, bus.instr[14:12]) ? bus.instr[31:25] : '0;
          state_d = dec_illegal ? S_TRAP : S_EXEC;
          illegal_d = dec_illegal;
        end
        S_EXEC: begin
          bus.pc_write = cls_q == C_BRANCH;
          bus.retired = cls_q == C_BRANCH;
          bus.pc_sel = (cls_q == C_BRANCH && bus.zero) ? PC_SEL_TGT : PC_SEL_PC4;
          state_d = cls_q == C_BRANCH ? S_FETCH : (cls_q inside {C_LOAD, C_STORE}) ? S_MEM : S_WB;
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we = cls_q == C_STORE;
          bus.pc_write = ready && cls_q == C_STORE;
          bus.retired = ready && cls_q == C_STORE;
          if (ready) state_d = cls_q == C_STORE ? S_FETCH : S_WB;
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.pc_write = 1'b1;
          bus.retired = 1'b1;
          bus.wb_sel = cls_q == C_LOAD ? WB_SEL_MEM : (cls_q inside {C_JAL, C_JALR}) ? WB_SEL_PC4 : WB_SEL_ALU;
          bus.pc_sel = cls_q == C_JAL ? PC_SEL_TGT : cls_q == C_JALR ? PC_SEL_JALR : PC_SEL_PC4;
          state_d = S_FETCH;
        end
        default: ;
      endcase
    end
  end

  // state, latched instruction fields, wait counter, retire count and sticky faults
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q <= C_R;
      f3_q <= '0;
      f7_q <= '0;
      wcnt_q <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      f3_q <= f3_d;
      f7_q <= f7_d;
      wcnt_q <= wcnt_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end
endmodule
